// File: rtl/riscv_mem_pkg.sv
// Shared types for the data-memory / write-back stage.
// Load and store op codes, access sizes and FSM states.
package riscv_mem_pkg;

   localparam int BYTE_EN_W = 4;

   typedef enum logic [2:0] {
      LD_NONE = 3'd0,
      LD_LB   = 3'd1,
      LD_LH   = 3'd2,
      LD_LW   = 3'd3,
      LD_LBU  = 3'd4,
      LD_LHU  = 3'd5
   } load_op_e;

   typedef enum logic [1:0] {
      ST_NONE = 2'd0,
      ST_SB   = 2'd1,
      ST_SH   = 2'd2,
      ST_SW   = 2'd3
   } store_op_e;

   typedef enum logic [1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2
   } size_e;

   typedef enum logic {
      IDLE      = 1'b0,
      WAIT_RESP = 1'b1
   } state_e;

   function automatic logic is_load(logic [2:0] op);
      return (op != 3'd0) && (op <= 3'd5);
   endfunction

endpackage

// File: rtl/mem_access_writeback_stage_if.sv
// Data-cache request/response bus.
// master = pipeline stage, slave = cache.
interface mem_access_writeback_stage_if
   import riscv_mem_pkg::*;
#(
   parameter int DATA_WIDTH = 32
);
   logic                  CACHE_REQ_VALID;
   logic                  CACHE_REQ_READY;
   logic                  CACHE_REQ_WRITE;
   logic [DATA_WIDTH-1:0] CACHE_REQ_ADDR;
   logic [DATA_WIDTH-1:0] CACHE_REQ_WDATA;
   logic [BYTE_EN_W-1:0]  CACHE_REQ_BYTE_EN;
   logic                  CACHE_RESP_VALID;
   logic [DATA_WIDTH-1:0] CACHE_RESP_DATA;

   modport master (
      output CACHE_REQ_VALID,
      output CACHE_REQ_WRITE,
      output CACHE_REQ_ADDR,
      output CACHE_REQ_WDATA,
      output CACHE_REQ_BYTE_EN,
      input  CACHE_REQ_READY,
      input  CACHE_RESP_VALID,
      input  CACHE_RESP_DATA
   );

   modport slave (
      input  CACHE_REQ_VALID,
      input  CACHE_REQ_WRITE,
      input  CACHE_REQ_ADDR,
      input  CACHE_REQ_WDATA,
      input  CACHE_REQ_BYTE_EN,
      output CACHE_REQ_READY,
      output CACHE_RESP_VALID,
      output CACHE_RESP_DATA
   );

endinterface

// File: rtl/load_data_aligner.sv
// Selects the addressed byte/half of a load word
// and sign- or zero-extends it to full width.
module load_data_aligner
   import riscv_mem_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0] word_in,
   input  logic [1:0]            addr_lo,
   input  logic [2:0]            load_op,
   output logic [DATA_WIDTH-1:0] data_out
);

   logic [DATA_WIDTH-1:0] byte_sh;
   logic [DATA_WIDTH-1:0] half_sh;

   assign byte_sh = word_in >> {addr_lo, 3'b000};
   assign half_sh = word_in >> {addr_lo[1], 4'b0000};

   // Extend the shifted lane according to the load op
   always_comb begin
      data_out = word_in;
      unique case (load_op)
         LD_LB:
            data_out = {{(DATA_WIDTH-8){byte_sh[7]}},
                        byte_sh[7:0]};
         LD_LBU:
            data_out = {{(DATA_WIDTH-8){1'b0}},
                        byte_sh[7:0]};
         LD_LH:
            data_out = {{(DATA_WIDTH-16){half_sh[15]}},
                        half_sh[15:0]};
         LD_LHU:
            data_out = {{(DATA_WIDTH-16){1'b0}},
                        half_sh[15:0]};
         default:
            data_out = word_in;
      endcase
   end

endmodule

// File: rtl/mem_access_writeback_stage.sv
// Data-memory access and write-back register stage.
// Issues cache requests, stalls upstream while busy.
module mem_access_writeback_stage
   import riscv_mem_pkg::*;
#(
   parameter int DATA_WIDTH       = 32,
   parameter int REG_ADD_WIDTH    = 5,
   parameter int D_CACHE_LW_WIDTH = 3,
   parameter int D_CACHE_SW_WIDTH = 2
) (
   input  logic                        CLK,
   input  logic                        RST_N,
   input  logic [REG_ADD_WIDTH-1:0]    RD_ADDRESS_IN,
   input  logic [DATA_WIDTH-1:0]       ALU_OUT_IN,
   input  logic [DATA_WIDTH-1:0]       STORE_DATA_IN,
   input  logic [D_CACHE_LW_WIDTH-1:0] DATA_CACHE_LOAD_IN,
   input  logic [D_CACHE_SW_WIDTH-1:0] DATA_CACHE_STORE_IN,
   input  logic                        WRITE_BACK_MUX_SELECT_IN,
   input  logic                        RD_WRITE_ENABLE_IN,
   mem_access_writeback_stage_if.master cache,
   output logic                        STALL_OUT,
   output logic [REG_ADD_WIDTH-1:0]    RD_ADDRESS_OUT,
   output logic [DATA_WIDTH-1:0]       WB_DATA_OUT,
   output logic                        RD_WRITE_ENABLE_OUT,
   output logic                        MISALIGNED_OUT
);

   state_e                state_q;
   state_e                state_d;
   size_e                 size;
   logic                  is_ld;
   logic                  is_st;
   logic                  mem_op;
   logic                  misaligned;
   logic                  access;
   logic                  req_valid;
   logic                  stall;
   logic [1:0]            addr_lo;
   logic [BYTE_EN_W-1:0]  byte_en;
   logic [DATA_WIDTH-1:0] wdata;
   logic [DATA_WIDTH-1:0] load_val;

   assign addr_lo = ALU_OUT_IN[1:0];
   assign is_ld   = is_load(DATA_CACHE_LOAD_IN);
   assign is_st   = !is_ld &&
                    (DATA_CACHE_STORE_IN != ST_NONE);
   assign mem_op  = is_ld || is_st;

   // Access size; a valid load code overrides any store
   always_comb begin
      size = SZ_W;
      if (is_ld) begin
         unique case (DATA_CACHE_LOAD_IN)
            LD_LB, LD_LBU: size = SZ_B;
            LD_LH, LD_LHU: size = SZ_H;
            default:       size = SZ_W;
         endcase
      end else begin
         unique case (DATA_CACHE_STORE_IN)
            ST_SB:   size = SZ_B;
            ST_SH:   size = SZ_H;
            default: size = SZ_W;
         endcase
      end
   end

   assign misaligned = mem_op &&
      ((size == SZ_H && addr_lo[0]) ||
       (size == SZ_W && addr_lo != 2'b00));
   assign access = mem_op && !misaligned;

   // Byte strobes and lane-replicated store data
   always_comb begin
      byte_en = 4'b1111;
      wdata   = STORE_DATA_IN;
      unique case (size)
         SZ_B: begin
            byte_en = 4'b0001 << addr_lo;
            wdata   = {4{STORE_DATA_IN[7:0]}};
         end
         SZ_H: begin
            byte_en = 4'b0011 << {addr_lo[1], 1'b0};
            wdata   = {2{STORE_DATA_IN[15:0]}};
         end
         default: begin
            byte_en = 4'b1111;
            wdata   = STORE_DATA_IN;
         end
      endcase
   end

   // Access FSM state register
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next state, request valid and stall
   always_comb begin
      state_d   = state_q;
      req_valid = 1'b0;
      stall     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (access) begin
               req_valid = 1'b1;
               if (cache.CACHE_REQ_READY) begin
                  if (is_ld) begin
                     state_d = WAIT_RESP;
                     stall   = 1'b1;
                  end
               end else begin
                  stall = 1'b1;
               end
            end
         end
         WAIT_RESP: begin
            if (cache.CACHE_RESP_VALID) state_d = IDLE;
            else                        stall   = 1'b1;
         end
      endcase
   end

   assign STALL_OUT               = stall;
   assign cache.CACHE_REQ_VALID   = req_valid;
   assign cache.CACHE_REQ_WRITE   = req_valid && is_st;
   assign cache.CACHE_REQ_ADDR    = req_valid ?
      {ALU_OUT_IN[DATA_WIDTH-1:2], 2'b00} : '0;
   assign cache.CACHE_REQ_WDATA   = req_valid ? wdata : '0;
   assign cache.CACHE_REQ_BYTE_EN = req_valid ? byte_en : '0;

   load_data_aligner #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_align (
      .word_in  (cache.CACHE_RESP_DATA),
      .addr_lo  (addr_lo),
      .load_op  (DATA_CACHE_LOAD_IN),
      .data_out (load_val)
   );

   // Write-back register; a bubble is written while stalled
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         RD_ADDRESS_OUT      <= '0;
         WB_DATA_OUT         <= '0;
         RD_WRITE_ENABLE_OUT <= 1'b0;
         MISALIGNED_OUT      <= 1'b0;
      end else if (!stall) begin
         RD_ADDRESS_OUT      <= RD_ADDRESS_IN;
         WB_DATA_OUT         <= WRITE_BACK_MUX_SELECT_IN ?
                                load_val : ALU_OUT_IN;
         RD_WRITE_ENABLE_OUT <= RD_WRITE_ENABLE_IN &&
                                !misaligned;
         MISALIGNED_OUT      <= misaligned;
      end else begin
         RD_WRITE_ENABLE_OUT <= 1'b0;
         MISALIGNED_OUT      <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mem_access_writeback_stage.sv
// Bench for mem_access_writeback_stage: directed
// vectors plus a per-cycle reference model.
module tb_mem_access_writeback_stage;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic [4:0]  rd_in;
   logic [31:0] alu_in;
   logic [31:0] sd_in;
   logic [2:0]  ld_in;
   logic [1:0]  st_in;
   logic        sel_in;
   logic        we_in;
   logic        stall;
   logic [4:0]  rd_out;
   logic [31:0] wb_out;
   logic        we_out;
   logic        mis_out;

   int checks = 0;
   int errors = 0;

   mem_access_writeback_stage_if bus ();

   mem_access_writeback_stage dut (
      .CLK                      (CLK),
      .RST_N                    (RST_N),
      .RD_ADDRESS_IN            (rd_in),
      .ALU_OUT_IN               (alu_in),
      .STORE_DATA_IN            (sd_in),
      .DATA_CACHE_LOAD_IN       (ld_in),
      .DATA_CACHE_STORE_IN      (st_in),
      .WRITE_BACK_MUX_SELECT_IN (sel_in),
      .RD_WRITE_ENABLE_IN       (we_in),
      .cache                    (bus),
      .STALL_OUT                (stall),
      .RD_ADDRESS_OUT           (rd_out),
      .WB_DATA_OUT              (wb_out),
      .RD_WRITE_ENABLE_OUT      (we_out),
      .MISALIGNED_OUT           (mis_out)
   );

   always #5 CLK = ~CLK;

   task automatic chk(string name, logic [31:0] act,
                      logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h @%0t",
                  name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic bit m_is_ld(logic [2:0] l);
      return (l >= 3'd1) && (l <= 3'd5);
   endfunction

   function automatic int m_nbytes(logic [2:0] l,
                                   logic [1:0] s);
      if (m_is_ld(l)) begin
         if (l == 3'd1 || l == 3'd4) return 1;
         if (l == 3'd2 || l == 3'd5) return 2;
         return 4;
      end
      if (s == 2'd1) return 1;
      if (s == 2'd2) return 2;
      return 4;
   endfunction

   function automatic logic [31:0] m_load(logic [2:0] l,
      logic [31:0] a, logic [31:0] w);
      int          nb;
      logic [31:0] v;
      nb = m_nbytes(l, 2'd0);
      v  = w >> (8 * int'(a[1:0]));
      if (nb == 4) return w;
      if (nb == 1) begin
         v = v & 32'hFF;
         if (l == 3'd1 && v >= 32'h80) v = v - 32'h100;
      end else begin
         v = v & 32'hFFFF;
         if (l == 3'd2 && v >= 32'h8000) v = v - 32'h10000;
      end
      return v;
   endfunction

   bit          m_wait;
   logic [4:0]  e_rd;
   logic [31:0] e_wb;
   bit          e_we;
   bit          e_mis;
   bit          c_ld, c_st, c_mem, c_mis, c_rv, c_stl;
   int          c_nb;
   logic [31:0] c_be, c_wd;

   // Compare DUT against the model every falling edge
   always @(negedge CLK) begin
      if (!RST_N) begin
         m_wait = 0;
         e_rd = '0; e_wb = '0; e_we = 0; e_mis = 0;
         chk("rst_we", {31'b0, we_out}, 32'd0);
         chk("rst_wb", wb_out, 32'd0);
         chk("rst_mis", {31'b0, mis_out}, 32'd0);
      end else begin
         c_ld  = m_is_ld(ld_in);
         c_st  = !c_ld && (st_in != 2'd0);
         c_mem = c_ld || c_st;
         c_nb  = m_nbytes(ld_in, st_in);
         c_mis = c_mem && ((int'(alu_in[1:0]) % c_nb) != 0);
         c_rv  = !m_wait && c_mem && !c_mis;
         c_stl = c_mem && !c_mis &&
                 !(!m_wait && c_st && bus.CACHE_REQ_READY) &&
                 !(m_wait && bus.CACHE_RESP_VALID);
         chk("m_req_valid", {31'b0, bus.CACHE_REQ_VALID},
             {31'b0, c_rv});
         chk("m_stall", {31'b0, stall}, {31'b0, c_stl});
         if (c_rv) begin
            c_be = ((32'd1 << c_nb) - 32'd1) << alu_in[1:0];
            if (c_nb == 1)
               c_wd = {24'b0, sd_in[7:0]} * 32'h01010101;
            else if (c_nb == 2)
               c_wd = {16'b0, sd_in[15:0]} * 32'h00010001;
            else
               c_wd = sd_in;
            chk("m_write", {31'b0, bus.CACHE_REQ_WRITE},
                {31'b0, c_st});
            chk("m_addr", bus.CACHE_REQ_ADDR,
                alu_in & 32'hFFFF_FFFC);
            chk("m_wdata", bus.CACHE_REQ_WDATA, c_wd);
            chk("m_be", {28'b0, bus.CACHE_REQ_BYTE_EN}, c_be);
         end else if (!c_mem && !m_wait) begin
            chk("m_idle_write",
                {31'b0, bus.CACHE_REQ_WRITE}, 32'd0);
            chk("m_idle_addr", bus.CACHE_REQ_ADDR, 32'd0);
            chk("m_idle_wdata", bus.CACHE_REQ_WDATA, 32'd0);
            chk("m_idle_be",
                {28'b0, bus.CACHE_REQ_BYTE_EN}, 32'd0);
         end
         chk("m_we", {31'b0, we_out}, {31'b0, e_we});
         chk("m_mis", {31'b0, mis_out}, {31'b0, e_mis});
         if (e_we) begin
            chk("m_rd", {27'b0, rd_out}, {27'b0, e_rd});
            chk("m_wb", wb_out, e_wb);
         end
         if (!c_stl) begin
            e_rd  = rd_in;
            e_wb  = sel_in ?
                    m_load(ld_in, alu_in, bus.CACHE_RESP_DATA) :
                    alu_in;
            e_we  = we_in && !c_mis;
            e_mis = c_mis;
         end else begin
            e_we  = 0;
            e_mis = 0;
         end
         if (!m_wait && c_ld && !c_mis && bus.CACHE_REQ_READY)
            m_wait = 1;
         else if (m_wait && bus.CACHE_RESP_VALID)
            m_wait = 0;
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic op(logic [2:0] l, logic [1:0] s,
                     logic [31:0] a, logic [31:0] d,
                     logic sel, logic we, logic [4:0] rd);
      ld_in = l; st_in = s; alu_in = a; sd_in = d;
      sel_in = sel; we_in = we; rd_in = rd;
   endtask

   task automatic nop();
      op(3'd0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0);
   endtask

   task automatic cache(logic r, logic v, logic [31:0] d);
      bus.CACHE_REQ_READY  = r;
      bus.CACHE_RESP_VALID = v;
      bus.CACHE_RESP_DATA  = d;
   endtask

   task automatic load1(string nm, logic [2:0] l,
                        logic [31:0] a, logic [31:0] w,
                        logic [4:0] rd, logic [31:0] exp);
      op(l, 2'd0, a, 32'd0, 1'b1, 1'b1, rd);
      cache(1'b1, 1'b0, 32'd0);
      step();
      cache(1'b0, 1'b1, w);
      step();
      nop();
      cache(1'b0, 1'b0, 32'd0);
      #1;
      chk(nm, wb_out, exp);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      RST_N = 1'b0;
      nop();
      cache(1'b0, 1'b0, 32'd0);
      step(); step();
      chk("reset_rd", {27'b0, rd_out}, 32'd0);
      chk("reset_wb", wb_out, 32'd0);
      chk("reset_we", {31'b0, we_out}, 32'd0);
      chk("reset_mis", {31'b0, mis_out}, 32'd0);
      chk("reset_stall", {31'b0, stall}, 32'd0);
      chk("reset_req", {31'b0, bus.CACHE_REQ_VALID}, 32'd0);
      RST_N = 1'b1;
      step();

      // 1: LW, one-cycle response
      op(3'd3, 2'd0, 32'h100, 32'd0, 1'b1, 1'b1, 5'd1);
      cache(1'b1, 1'b0, 32'd0);
      #1;
      chk("t1_req", {31'b0, bus.CACHE_REQ_VALID}, 32'd1);
      chk("t1_stall_acc", {31'b0, stall}, 32'd1);
      chk("t1_addr", bus.CACHE_REQ_ADDR, 32'h100);
      chk("t1_be", {28'b0, bus.CACHE_REQ_BYTE_EN}, 32'hF);
      step();
      cache(1'b0, 1'b1, 32'hDEADBEEF);
      #1;
      chk("t1_stall_resp", {31'b0, stall}, 32'd0);
      step();
      nop();
      cache(1'b0, 1'b0, 32'd0);
      chk("t1_wb", wb_out, 32'hDEADBEEF);
      chk("t1_we", {31'b0, we_out}, 32'd1);
      chk("t1_rd", {27'b0, rd_out}, 32'd1);

      // 2: byte/half loads
      op(3'd1, 2'd0, 32'h103, 32'd0, 1'b1, 1'b1, 5'd2);
      cache(1'b1, 1'b0, 32'd0);
      #1;
      chk("t2_be", {28'b0, bus.CACHE_REQ_BYTE_EN}, 32'h8);
      load1("t2_lb", 3'd1, 32'h103, 32'h80FFFF00, 5'd2,
            32'hFFFFFF80);
      load1("t2_lbu", 3'd4, 32'h103, 32'h80FFFF00, 5'd2,
            32'h00000080);
      load1("t2_lh", 3'd2, 32'h102, 32'h80FFFF00, 5'd3,
            32'hFFFF80FF);
      load1("t2_lhu", 3'd5, 32'h102, 32'h80FFFF00, 5'd3,
            32'h000080FF);
      load1("t2_lb0", 3'd1, 32'h100, 32'h80FFFF7F, 5'd4,
            32'h0000007F);

      // 3: SH with READY low for three cycles
      op(3'd0, 2'd2, 32'h102, 32'h1234ABCD, 1'b0, 1'b0, 5'd0);
      cache(1'b0, 1'b0, 32'd0);
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("t3_stall", {31'b0, stall}, 32'd1);
         chk("t3_wdata", bus.CACHE_REQ_WDATA, 32'hABCDABCD);
         chk("t3_be", {28'b0, bus.CACHE_REQ_BYTE_EN}, 32'hC);
         chk("t3_write", {31'b0, bus.CACHE_REQ_WRITE}, 32'd1);
         step();
      end
      cache(1'b1, 1'b0, 32'd0);
      #1;
      chk("t3_stall_acc", {31'b0, stall}, 32'd0);
      step();
      nop();
      cache(1'b0, 1'b0, 32'd0);
      chk("t3_we", {31'b0, we_out}, 32'd0);
      op(3'd0, 2'd1, 32'h101, 32'h000000EF, 1'b0, 1'b0, 5'd0);
      cache(1'b1, 1'b0, 32'd0);
      #1;
      chk("t3_sb_wdata", bus.CACHE_REQ_WDATA, 32'hEFEFEFEF);
      chk("t3_sb_be", {28'b0, bus.CACHE_REQ_BYTE_EN}, 32'h2);
      step();
      op(3'd0, 2'd3, 32'h104, 32'hCAFEF00D, 1'b0, 1'b0, 5'd0);
      step();

      // 4: misaligned LW is dropped
      op(3'd3, 2'd0, 32'h101, 32'd0, 1'b1, 1'b1, 5'd7);
      cache(1'b1, 1'b0, 32'd0);
      #1;
      chk("t4_req", {31'b0, bus.CACHE_REQ_VALID}, 32'd0);
      chk("t4_stall", {31'b0, stall}, 32'd0);
      step();
      nop();
      cache(1'b0, 1'b0, 32'd0);
      chk("t4_mis", {31'b0, mis_out}, 32'd1);
      chk("t4_we", {31'b0, we_out}, 32'd0);
      step();
      chk("t4_mis_end", {31'b0, mis_out}, 32'd0);

      // 5: reset during WAIT_RESP, stale response
      op(3'd3, 2'd0, 32'h200, 32'd0, 1'b1, 1'b1, 5'd3);
      cache(1'b1, 1'b0, 32'd0);
      step();
      cache(1'b0, 1'b0, 32'd0);
      nop();
      RST_N = 1'b0;
      #1;
      chk("t5_rst_stall", {31'b0, stall}, 32'd0);
      chk("t5_rst_we", {31'b0, we_out}, 32'd0);
      step();
      RST_N = 1'b1;
      cache(1'b0, 1'b1, 32'h55555555);
      #1;
      chk("t5_stale_stall", {31'b0, stall}, 32'd0);
      chk("t5_stale_req", {31'b0, bus.CACHE_REQ_VALID}, 32'd0);
      step();
      chk("t5_we", {31'b0, we_out}, 32'd0);
      chk("t5_wb", wb_out, 32'd0);
      op(3'd3, 2'd0, 32'h300, 32'd0, 1'b1, 1'b1, 5'd9);
      cache(1'b1, 1'b1, 32'h55555555);
      #1;
      chk("t5_idle_resp_ign", {31'b0, stall}, 32'd1);
      step();
      cache(1'b0, 1'b1, 32'h0A0B0C0D);
      step();
      nop();
      cache(1'b0, 1'b0, 32'd0);
      chk("t5_wb_new", wb_out, 32'h0A0B0C0D);

      // 6: ALU op then load, bubbles during stall
      op(3'd0, 2'd0, 32'h42, 32'd0, 1'b0, 1'b1, 5'd5);
      step();
      chk("t6_alu_wb", wb_out, 32'h42);
      chk("t6_alu_we", {31'b0, we_out}, 32'd1);
      chk("t6_alu_rd", {27'b0, rd_out}, 32'd5);
      op(3'd3, 2'd0, 32'h104, 32'd0, 1'b1, 1'b1, 5'd6);
      cache(1'b1, 1'b0, 32'd0);
      step();
      chk("t6_bubble0", {31'b0, we_out}, 32'd0);
      cache(1'b0, 1'b0, 32'd0);
      step();
      chk("t6_bubble1", {31'b0, we_out}, 32'd0);
      cache(1'b0, 1'b1, 32'h11223344);
      step();
      nop();
      cache(1'b0, 1'b0, 32'd0);
      chk("t6_ld_wb", wb_out, 32'h11223344);
      chk("t6_ld_rd", {27'b0, rd_out}, 32'd6);
      chk("t6_ld_we", {31'b0, we_out}, 32'd1);
      step();
      chk("t6_no_dup", {31'b0, we_out}, 32'd0);

      // Load and store together: load wins
      op(3'd3, 2'd2, 32'h108, 32'h0000FFFF, 1'b1, 1'b1, 5'd8);
      cache(1'b1, 1'b0, 32'd0);
      #1;
      chk("both_write", {31'b0, bus.CACHE_REQ_WRITE}, 32'd0);
      chk("both_be", {28'b0, bus.CACHE_REQ_BYTE_EN}, 32'hF);
      step();
      cache(1'b0, 1'b1, 32'h76543210);
      step();
      nop();
      cache(1'b0, 1'b0, 32'd0);
      chk("both_wb", wb_out, 32'h76543210);
      step(); step();

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
